fetch_control_unit: RTL and testbench
=====================================

# fetch_control_unit

Sequencing controller for the instruction-fetch stage and the IF/ID pipeline register. Each cycle it decides whether the PC advances, whether the next-PC mux selects the branch target, and whether IF/ID is loaded, held or flushed. Inputs are the ID-stage hazard and branch signals plus a debug halt/step port. It also keeps fetch and stall counters for performance checks.

## Interface
- STALL_CYCLES, 1: cycles the PC and IF/ID are frozen per load-use hazard; legal range 1..15.
- BOOT_CYCLES, 1: cycles after reset before the first PC advance (covers the synchronous instruction-memory read); legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_use_hazard  in  1  ID-stage load-use dependency detected this cycle.
- branch_taken  in  1  ID-stage branch/jump resolved taken this cycle.
- halt_req  in  1  debug request to stop fetching.
- step_req  in  1  debug request to fetch one instruction while halted.
- resume  in  1  debug request to leave halt.
- PCWrite  out  1  PC register load enable.
- PCSrc  out  1  next-PC mux select: 1 = branch target, 0 = PC+4.
- IFID_write  out  1  IF/ID register load enable.
- IFID_flush  out  1  clear IF/ID to NOP on the next edge.
- IDEX_bubble  out  1  force ID/EX control fields to zero.
- halted  out  1  controller is in HALT.
- fetch_count  out  32  number of cycles with PCWrite=1; wraps modulo 2^32.
- stall_count  out  16  number of hazard-stall cycles; saturates at 0xFFFF.

## Operation
- States: BOOT, RUN, STALL, HALT, STEP. A 4-bit down-counter `cnt` is used by BOOT and STALL. A flag `from_step` records whether STALL was entered from STEP.
- BOOT:
  - Outputs: PCWrite=0, IFID_write=0, IFID_flush=1, IDEX_bubble=1.
  - `cnt` is loaded with BOOT_CYCLES-1 on reset. When `cnt`=0, go to RUN; otherwise decrement.
  - Debug inputs are ignored.
- RUN, evaluated in priority order:
  1. load_use_hazard: PCWrite=0, IFID_write=0, IDEX_bubble=1. If STALL_CYCLES>1, go to STALL with `cnt`=STALL_CYCLES-2; otherwise stay in RUN. branch_taken and halt_req are ignored this cycle.
  2. branch_taken: PCSrc=1, PCWrite=1, IFID_write=1, IFID_flush=1. If halt_req is also set, go to HALT after this cycle.
  3. Otherwise: PCWrite=1, IFID_write=1. If halt_req, go to HALT; the halt-request cycle itself still fetches.
- STALL:
  - Outputs: PCWrite=0, IFID_write=0, IDEX_bubble=1.
  - Inputs are ignored. The hazard unit re-presents any pending branch after the stall.
  - When `cnt`=0, go to HALT if `from_step` is set, else RUN; otherwise decrement.
- HALT:
  - Outputs: PCWrite=0, IFID_write=0, IDEX_bubble=1, halted=1.
  - resume goes to RUN. step_req alone goes to STEP. resume has priority over step_req.
  - halt_req is ignored.
- STEP:
  - Outputs follow the RUN rules exactly for one cycle; halted=0.
  - Then return to HALT, or go to STALL with `from_step`=1 per rule 1.
  - halt_req is ignored.
- Unless stated otherwise above, every output defaults to 0.
- Counters:
  - fetch_count increments on every edge where PCWrite=1.
  - stall_count increments on every edge where a load-use stall is active (RUN/STEP rule 1, or STALL). BOOT and HALT bubbles are not counted.
- Reset mid-operation: on any state, the next edge returns to BOOT and the count restarts. A stall or step in progress is abandoned.

## Timing
- Outputs are combinational from the state, `cnt` and the current-cycle inputs (Mealy). No output is registered. Decisions take effect on the next rising edge of clk.
- While rst=1: PCWrite=0, PCSrc=0, IFID_write=0, IFID_flush=1, IDEX_bubble=1, halted=0, regardless of state.
- After the reset edge: state=BOOT, fetch_count=0, stall_count=0, `from_step`=0.
- First PCWrite=1 occurs on cycle BOOT_CYCLES after rst deasserts, counting from 0.
- Load-use: PCWrite is low for exactly STALL_CYCLES consecutive cycles starting in the hazard cycle.
- Branch: one-cycle redirect with one flushed slot. There is no extra penalty cycle.
- Halt latency: one fetch cycle after halt_req is sampled; halted=1 from the next cycle.
- Step: exactly one PCWrite=1 cycle per step_req, unless a stall occurs. A load-use in STEP gives zero advance followed by STALL_CYCLES-1 STALL cycles, then HALT.

## Test plan
- Reset with defaults, no hazards, 10 cycles after rst falls: PCWrite=0 in cycle 0 and 1 in cycles 1..9; fetch_count=9; IFID_flush=1 only in cycle 0.
- STALL_CYCLES=3, load_use_hazard pulsed for one cycle in RUN: PCWrite and IFID_write low for 3 cycles, IDEX_bubble high for 3 cycles, stall_count=3.
- load_use_hazard and branch_taken both high in the same cycle: PCSrc=0, PCWrite=0, no flush. Then branch_taken alone: PCSrc=1, IFID_flush=1, PCWrite=1.
- halt_req with branch_taken: redirect completes, halted=1 next cycle, PCWrite stays 0 for 20 cycles. Then step_req+resume together: RUN is entered, halted=0.
- Halted with STALL_CYCLES=2: step_req while load_use_hazard=1 gives 2 cycles of PCWrite=0 and a return to HALT. Then step_req alone gives exactly 1 PCWrite cycle and fetch_count+1.
- rst asserted in STALL with `cnt`=1: BOOT next, counters=0, normal fetch resumes after BOOT_CYCLES.

Source files
------------

// File: rtl/fetch_control_unit.sv
// fetch_control_unit: sequences PC advance, next-PC select and IF/ID load/hold/flush with debug halt/step.
module fetch_control_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int BOOT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use_hazard,
  input  logic        branch_taken,
  input  logic        halt_req,
  input  logic        step_req,
  input  logic        resume,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        IFID_write,
  output logic        IFID_flush,
  output logic        IDEX_bubble,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [15:0] stall_count
);
  typedef enum logic [2:0] {BOOT, RUN, STALL, HALT, STEP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic from_step;
  logic run_like, hz, br, stall_active;
  always_comb begin
    run_like = state == RUN || state == STEP;
    hz = run_like && load_use_hazard;
    br = run_like && !load_use_hazard && branch_taken;
    stall_active = hz || state == STALL;
    PCWrite = !rst && run_like && !load_use_hazard;
    IFID_write = PCWrite;
    PCSrc = !rst && br;
    IFID_flush = rst || state == BOOT || br;
    IDEX_bubble = rst || state == BOOT || state == HALT || stall_active;
    halted = !rst && state == HALT;
  end
  // A STEP stall returns to HALT; a RUN stall returns to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      cnt <= 4'(BOOT_CYCLES - 1);
      from_step <= 1'b0;
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (PCWrite) fetch_count <= fetch_count + 32'd1;
      if (stall_active && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      case (state)
        BOOT: begin
          if (cnt == 4'd0) state <= RUN;
          else cnt <= cnt - 4'd1;
        end
        RUN: begin
          if (load_use_hazard) begin
            if (STALL_CYCLES > 1) begin
              state <= STALL;
              cnt <= 4'(STALL_CYCLES - 2);
              from_step <= 1'b0;
            end
          end else if (halt_req) state <= HALT;
        end
        STEP: begin
          if (load_use_hazard && STALL_CYCLES > 1) begin
            state <= STALL;
            cnt <= 4'(STALL_CYCLES - 2);
            from_step <= 1'b1;
          end else state <= HALT;
        end
        STALL: begin
          if (cnt == 4'd0) state <= from_step ? HALT : RUN;
          else cnt <= cnt - 4'd1;
        end
        HALT: begin
          if (resume) state <= RUN;
          else if (step_req) state <= STEP;
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_control_unit.sv
// tb_fetch_control_unit: directed scenario tasks for fetch_control_unit (BOOT_CYCLES=1, STALL_CYCLES=3).
module tb_fetch_control_unit;
  logic clk = 0, rst = 1;
  logic load_use_hazard = 0, branch_taken = 0, halt_req = 0, step_req = 0, resume = 0;
  logic PCWrite, PCSrc, IFID_write, IFID_flush, IDEX_bubble, halted;
  logic [31:0] fetch_count;
  logic [15:0] stall_count;
  int checks = 0, errors = 0;
  logic [31:0] fc0;
  logic [15:0] sc0;

  fetch_control_unit #(.STALL_CYCLES(3), .BOOT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
    .halt_req(halt_req), .step_req(step_req), .resume(resume), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .IFID_write(IFID_write), .IFID_flush(IFID_flush), .IDEX_bubble(IDEX_bubble), .halted(halted),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    tick();
    tick();
    #1;
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL rst_pcwrite got %b exp 0", PCWrite); end
    checks++; if (IFID_flush !== 1'b1) begin errors++; $display("FAIL rst_flush got %b exp 1", IFID_flush); end
    checks++; if (IDEX_bubble !== 1'b1) begin errors++; $display("FAIL rst_bubble got %b exp 1", IDEX_bubble); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rst_fetch_count got %0d exp 0", fetch_count); end
    rst = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (PCWrite !== (i > 0)) begin errors++; $display("FAIL boot_pcwrite cyc %0d got %b exp %b", i, PCWrite, i > 0); end
      checks++; if (IFID_flush !== (i == 0)) begin errors++; $display("FAIL boot_flush cyc %0d got %b exp %b", i, IFID_flush, i == 0); end
      tick();
    end
    checks++; if (fetch_count !== 32'd9) begin errors++; $display("FAIL boot_fetch_count got %0d exp 9", fetch_count); end
  endtask

  task automatic test_load_use;
    sc0 = stall_count;
    load_use_hazard = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL lu_pcwrite cyc %0d got %b exp 0", i, PCWrite); end
      checks++; if (IFID_write !== 1'b0) begin errors++; $display("FAIL lu_ifid_write cyc %0d got %b exp 0", i, IFID_write); end
      checks++; if (IDEX_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble cyc %0d got %b exp 1", i, IDEX_bubble); end
      tick();
      load_use_hazard = 0;
      #1;
    end
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL lu_resume got %b exp 1", PCWrite); end
    checks++; if (IDEX_bubble !== 1'b0) begin errors++; $display("FAIL lu_bubble_end got %b exp 0", IDEX_bubble); end
    checks++; if (stall_count !== sc0 + 16'd3) begin errors++; $display("FAIL lu_stall_count got %0d exp %0d", stall_count, sc0 + 16'd3); end
  endtask

  task automatic test_hazard_vs_branch;
    load_use_hazard = 1;
    branch_taken = 1;
    #1;
    checks++; if (PCSrc !== 1'b0) begin errors++; $display("FAIL hb_pcsrc got %b exp 0", PCSrc); end
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL hb_pcwrite got %b exp 0", PCWrite); end
    checks++; if (IFID_flush !== 1'b0) begin errors++; $display("FAIL hb_flush got %b exp 0", IFID_flush); end
    tick();
    load_use_hazard = 0;
    branch_taken = 0;
    tick();
    tick();
    branch_taken = 1;
    #1;
    checks++; if (PCSrc !== 1'b1) begin errors++; $display("FAIL br_pcsrc got %b exp 1", PCSrc); end
    checks++; if (IFID_flush !== 1'b1) begin errors++; $display("FAIL br_flush got %b exp 1", IFID_flush); end
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL br_pcwrite got %b exp 1", PCWrite); end
    tick();
    branch_taken = 0;
    #1;
    checks++; if (PCSrc !== 1'b0 || IFID_flush !== 1'b0) begin errors++; $display("FAIL br_after got %b%b exp 00", PCSrc, IFID_flush); end
  endtask

  task automatic test_halt;
    branch_taken = 1;
    halt_req = 1;
    #1;
    checks++; if (PCWrite !== 1'b1 || PCSrc !== 1'b1) begin errors++; $display("FAIL halt_redirect got %b%b exp 11", PCWrite, PCSrc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b exp 0", halted); end
    tick();
    branch_taken = 0;
    halt_req = 0;
    #1;
    fc0 = fetch_count;
    for (int i = 0; i < 20; i++) begin
      checks++; if (PCWrite !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_hold cyc %0d pcwrite %b halted %b exp 0 1", i, PCWrite, halted); end
      tick();
    end
    checks++; if (fetch_count !== fc0) begin errors++; $display("FAIL halt_fetch_count got %0d exp %0d", fetch_count, fc0); end
    step_req = 1;
    resume = 1;
    tick();
    step_req = 0;
    resume = 0;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume_halted got %b exp 0", halted); end
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL resume_pcwrite got %b exp 1", PCWrite); end
    tick();
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL resume_run got %b exp 1", PCWrite); end
  endtask

  task automatic test_step;
    halt_req = 1;
    tick();
    halt_req = 0;
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL step_pre_halt got %b exp 1", halted); end
    fc0 = fetch_count;
    sc0 = stall_count;
    step_req = 1;
    load_use_hazard = 1;
    tick();
    step_req = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (PCWrite !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL step_lu cyc %0d pcwrite %b halted %b exp 0 0", i, PCWrite, halted); end
      tick();
      load_use_hazard = 0;
      #1;
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL step_lu_rehalt got %b exp 1", halted); end
    checks++; if (fetch_count !== fc0) begin errors++; $display("FAIL step_lu_fetch got %0d exp %0d", fetch_count, fc0); end
    checks++; if (stall_count !== sc0 + 16'd3) begin errors++; $display("FAIL step_lu_stall got %0d exp %0d", stall_count, sc0 + 16'd3); end
    step_req = 1;
    tick();
    step_req = 0;
    #1;
    checks++; if (PCWrite !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL step_fetch pcwrite %b halted %b exp 1 0", PCWrite, halted); end
    tick();
    checks++; if (halted !== 1'b1 || PCWrite !== 1'b0) begin errors++; $display("FAIL step_back halted %b pcwrite %b exp 1 0", halted, PCWrite); end
    checks++; if (fetch_count !== fc0 + 32'd1) begin errors++; $display("FAIL step_fetch_count got %0d exp %0d", fetch_count, fc0 + 32'd1); end
    resume = 1;
    tick();
    resume = 0;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL step_resume got %b exp 1", PCWrite); end
  endtask

  task automatic test_reset_in_stall;
    load_use_hazard = 1;
    tick();
    load_use_hazard = 0;
    #1;
    checks++; if (IDEX_bubble !== 1'b1 || PCWrite !== 1'b0) begin errors++; $display("FAIL mid_stall bubble %b pcwrite %b exp 1 0", IDEX_bubble, PCWrite); end
    rst = 1;
    #1;
    checks++; if (PCWrite !== 1'b0 || PCSrc !== 1'b0 || IFID_flush !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL mid_rst_outputs got %b%b%b%b exp 0010", PCWrite, PCSrc, IFID_flush, halted); end
    tick();
    rst = 0;
    #1;
    checks++; if (fetch_count !== 32'd0 || stall_count !== 16'd0) begin errors++; $display("FAIL mid_rst_counts got %0d %0d exp 0 0", fetch_count, stall_count); end
    checks++; if (PCWrite !== 1'b0 || IFID_flush !== 1'b1) begin errors++; $display("FAIL mid_rst_boot pcwrite %b flush %b exp 0 1", PCWrite, IFID_flush); end
    tick();
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL mid_rst_fetch got %b exp 1", PCWrite); end
    tick();
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL mid_rst_fetch_count got %0d exp 1", fetch_count); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_hazard_vs_branch();
    test_halt();
    test_step();
    test_reset_in_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
